// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode/state types and constants for the 9-bit CPU
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_XOR = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_ADD = 3'b100,
        OP_LW  = 3'b101,
        OP_SW  = 3'b110,
        OP_BR  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } seq_state_t;

    localparam logic [8:0] HALT_IR = 9'b111_000000;

    function automatic logic is_mem_op(input opcode_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - ROM, datapath and data-memory signals seen by the sequencer
interface cpu_sequencer_if #(
    parameter int PC_W = 10
);
    logic [PC_W-1:0] pc_o;
    logic [8:0]      instr_i;
    logic            br_cond_i;
    logic            mem_ack_i;
    logic [8:0]      ir_o;
    logic            rf_we_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic            busy_o;
    logic            done_o;
    logic [2:0]      state_o;

    modport master (
        output pc_o, ir_o, rf_we_o, mem_req_o, mem_we_o, busy_o, done_o, state_o,
        input  instr_i, br_cond_i, mem_ack_i
    );

    modport slave (
        input  pc_o, ir_o, rf_we_o, mem_req_o, mem_we_o, busy_o, done_o, state_o,
        output instr_i, br_cond_i, mem_ack_i
    );
endinterface

// File: rtl/seq_perf_counters.sv
// rtl/seq_perf_counters.sv - saturating busy-cycle and retired-instruction counters
module seq_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_busy,
    input  logic        i_retire,
    output logic [31:0] o_cyc_cnt,
    output logic [31:0] o_ret_cnt
);
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_ret_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cyc_cnt <= '0;
            r_ret_cnt <= '0;
        end else begin
            if (i_busy && (r_cyc_cnt != 32'hFFFF_FFFF)) begin
                r_cyc_cnt <= r_cyc_cnt + 32'd1;
            end
            if (i_retire && (r_ret_cnt != 32'hFFFF_FFFF)) begin
                r_ret_cnt <= r_ret_cnt + 32'd1;
            end
        end
    end

    assign o_cyc_cnt = r_cyc_cnt;
    assign o_ret_cnt = r_ret_cnt;
endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR
// Optional SEQ_PERF_CNT_EN adds cyc_cnt_o/ret_cnt_o performance counters.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    cpu_sequencer_if.master      bus
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]          cyc_cnt_o,
    output logic [31:0]          ret_cnt_o
`endif
);
    seq_state_t      r_state;
    seq_state_t      w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_next_pc;
    logic [8:0]      r_ir;
    logic [8:0]      w_next_ir;
    opcode_t         w_op;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_br_off;
    logic [PC_W-1:0] w_br_target;
    logic            w_rf_we;
    logic            w_mem_req;
    logic            w_mem_we;
    logic            w_busy;
    logic            w_done;

    assign w_op        = opcode_t'(r_ir[8:6]);
    assign w_pc_inc    = r_pc + PC_W'(1);
    // Offset is relative to the branch's own PC; sign extension also handles PC_W < 6.
    assign w_br_off    = PC_W'($signed(r_ir[5:0]));
    assign w_br_target = r_pc + w_br_off;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_ir    <= w_next_ir;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_ir    = r_ir;
        w_rf_we      = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_FETCH;
                    w_next_pc    = '0;
                end
            end
            S_FETCH: begin
                w_busy       = 1'b1;
                w_next_ir    = bus.instr_i;
                w_next_state = (bus.instr_i == HALT_IR) ? S_HALT : S_DECODE;
            end
            S_DECODE: begin
                w_busy       = 1'b1;
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                w_busy = 1'b1;
                if (is_mem_op(w_op)) begin
                    w_next_state = S_MEM;
                end else if (w_op == OP_BR) begin
                    w_next_pc    = bus.br_cond_i ? w_br_target : w_pc_inc;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                w_busy    = 1'b1;
                w_mem_req = 1'b1;
                w_mem_we  = (w_op == OP_SW);
                if (bus.mem_ack_i) begin
                    if (w_op == OP_SW) begin
                        w_next_pc    = w_pc_inc;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                w_busy       = 1'b1;
                w_rf_we      = 1'b1;
                w_next_pc    = w_pc_inc;
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                w_done = 1'b1;
                if (start) begin
                    w_next_state = S_FETCH;
                    w_next_pc    = '0;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.pc_o      = r_pc;
    assign bus.ir_o      = r_ir;
    assign bus.rf_we_o   = w_rf_we;
    assign bus.mem_req_o = w_mem_req;
    assign bus.mem_we_o  = w_mem_we;
    assign bus.busy_o    = w_busy;
    assign bus.done_o    = w_done;
    assign bus.state_o   = r_state;

`ifdef SEQ_PERF_CNT_EN
    logic w_start_acc;
    logic w_retire;

    assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_HALT));
    // Every instruction retires in its final cycle, including the HALT fetch.
    assign w_retire    = (r_state == S_WB)
                       || ((r_state == S_MEM) && bus.mem_ack_i && (w_op == OP_SW))
                       || ((r_state == S_EXEC) && (w_op == OP_BR))
                       || ((r_state == S_FETCH) && (bus.instr_i == HALT_IR));

    seq_perf_counters u_perf (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_start_acc),
        .i_busy    (w_busy),
        .i_retire  (w_retire),
        .o_cyc_cnt (cyc_cnt_o),
        .o_ret_cnt (ret_cnt_o)
    );
`endif
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed and randomized program runs against an instruction-level model
module tb_cpu_sequencer;
    localparam int PC_W  = 4;
    localparam int ROM_N = 1 << PC_W;
    localparam logic [8:0] HALT = 9'b111_000000;

    typedef struct {
        int         pc;
        logic [8:0] ir;
        bit         rf_we;
        bit         mem_req;
        bit         mem_we;
        bit         busy;
        bit         done;
        int         cyc;
        int         ret;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic ack = 1'b0;
    logic [8:0] rom [ROM_N];
    bit         bcond [ROM_N];
    int         waits [ROM_N];
    exp_t       exp_q [$];
    int         n_checks = 0;
    int         n_pass = 0;

    cpu_sequencer_if #(.PC_W(PC_W)) bus ();

    assign bus.instr_i   = rom[bus.pc_o];
    assign bus.br_cond_i = bcond[bus.pc_o];
    assign bus.mem_ack_i = ack;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;
`endif

    cpu_sequencer #(.PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cyc_cnt_o (cyc_cnt),
        .ret_cnt_o (ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    endtask

    function automatic void push(input int pc, input logic [8:0] ir, input bit rf_we,
                                 input bit mreq, input bit mwe, input bit busy,
                                 input bit done, input int cyc, input int ret);
        exp_t e;
        e.pc = pc; e.ir = ir; e.rf_we = rf_we; e.mem_req = mreq; e.mem_we = mwe;
        e.busy = busy; e.done = done; e.cyc = cyc; e.ret = ret;
        exp_q.push_back(e);
    endfunction

    // Instruction-level model: expands each instruction into its cycle-by-cycle outputs.
    task automatic build_trace(input logic [8:0] ir0, input int max_cyc, output bit halted);
        int pc = 0, cyc = 0, ret = 0, off;
        logic [8:0] ir = ir0, instr;
        logic [2:0] op;
        halted = 0;
        exp_q.delete();
        while (exp_q.size() < max_cyc) begin
            instr = rom[pc];
            push(pc, ir, 0, 0, 0, 1, 0, cyc, ret); cyc++;
            ir = instr;
            if (instr == HALT) begin
                ret++;
                halted = 1;
                while (exp_q.size() < max_cyc) push(pc, ir, 0, 0, 0, 0, 1, cyc, ret);
                break;
            end
            op = ir[8:6];
            push(pc, ir, 0, 0, 0, 1, 0, cyc, ret); cyc++;
            push(pc, ir, 0, 0, 0, 1, 0, cyc, ret); cyc++;
            if (op == 3'b111) begin
                off = int'($signed(ir[5:0]));
                pc = bcond[pc] ? ((pc + off) & (ROM_N - 1)) : ((pc + 1) % ROM_N);
                ret++;
            end else if (op == 3'b101 || op == 3'b110) begin
                for (int k = 0; k <= waits[pc]; k++) begin
                    push(pc, ir, 0, 1, op == 3'b110, 1, 0, cyc, ret); cyc++;
                end
                if (op == 3'b101) begin
                    push(pc, ir, 1, 0, 0, 1, 0, cyc, ret); cyc++;
                end
                ret++;
                pc = (pc + 1) % ROM_N;
            end else begin
                push(pc, ir, 1, 0, 0, 1, 0, cyc, ret); cyc++;
                ret++;
                pc = (pc + 1) % ROM_N;
            end
        end
    endtask

    task automatic reset_chk();
        reset = 1'b1; start = 1'b0; ack = 1'b0;
        @(negedge clk);
        check("rst_state", bus.state_o, 0);
        check("rst_pc", bus.pc_o, 0);
        check("rst_ir", bus.ir_o, 0);
        check("rst_rf_we", bus.rf_we_o, 0);
        check("rst_mem_req", bus.mem_req_o, 0);
        check("rst_mem_we", bus.mem_we_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
`ifdef SEQ_PERF_CNT_EN
        check("rst_cyc_cnt", cyc_cnt, 0);
        check("rst_ret_cnt", ret_cnt, 0);
`endif
        reset = 1'b0;
    endtask

    // Runs one program from start; with cut_sw, resets the DUT inside the first SW MEM cycle.
    task automatic run(input bit from_halt, input int max_cyc, input bit cut_sw, output bit halted);
        int cut, mem_cnt = 0;
        bit did_cut = 0;
        build_trace(from_halt ? HALT : 9'd0, max_cyc, halted);
        cut = exp_q.size();
        if (cut_sw) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].mem_we) begin cut = i; did_cut = 1; break; end
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < cut; i++) begin
            check("pc", bus.pc_o, exp_q[i].pc);
            check("ir", bus.ir_o, exp_q[i].ir);
            check("rf_we", bus.rf_we_o, exp_q[i].rf_we);
            check("mem_req", bus.mem_req_o, exp_q[i].mem_req);
            check("mem_we", bus.mem_req_o ? bus.mem_we_o : 1'b0, exp_q[i].mem_we);
            check("busy", bus.busy_o, exp_q[i].busy);
            check("done", bus.done_o, exp_q[i].done);
`ifdef SEQ_PERF_CNT_EN
            check("cyc_cnt", cyc_cnt, exp_q[i].cyc);
            check("ret_cnt", ret_cnt, exp_q[i].ret);
`endif
            if (exp_q[i].mem_req) begin
                ack = (mem_cnt == waits[exp_q[i].pc]);
                mem_cnt++;
            end else begin
                mem_cnt = 0;
                ack = ($urandom_range(0, 3) == 0);
            end
            start = exp_q[i].busy && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        ack = 1'b0;
        if (did_cut) begin
            reset_chk();
            halted = 0;
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < ROM_N; i++) begin
            rom[i] = 9'b100_000000;
            bcond[i] = 0;
            waits[i] = 0;
        end
    endtask

    initial begin
        bit h;
        reset_chk();

        clear_prog();                       // ADD, HALT; then restart from HALT
        rom[1] = HALT;
        run(0, 10, 0, h);
        check("t1_halted_model", h, 1);
        run(1, 10, 0, h);

        reset_chk(); clear_prog();          // LW with ack in third MEM cycle
        rom[0] = 9'b101_000011; rom[1] = HALT; waits[0] = 2;
        run(0, 12, 0, h);

        reset_chk(); clear_prog();          // BR at pc 5, taken backward and not taken
        rom[0] = 9'b111_000101; bcond[0] = 1;
        rom[5] = 9'b111_111110; bcond[5] = 1; rom[3] = HALT; rom[6] = HALT;
        run(0, 14, 0, h);
        reset_chk(); bcond[5] = 0;
        run(0, 14, 0, h);

        reset_chk(); clear_prog();          // wrap: BR -1 to pc 15, ALU there wraps to 0
        rom[0] = 9'b111_111111; bcond[0] = 1; rom[15] = 9'b000_010101;
        run(0, 20, 0, h);

        reset_chk(); clear_prog();          // reset inside SW MEM
        rom[0] = 9'b110_000001; waits[0] = 3; rom[1] = HALT;
        run(0, 12, 1, h);

        clear_prog();                       // ADD, SW(1 cycle ack), HALT
        rom[1] = 9'b110_000000; rom[2] = HALT;
        run(0, 12, 0, h);

        for (int it = 0; it < 25; it++) begin
            reset_chk();
            for (int i = 0; i < ROM_N; i++) begin
                rom[i] = 9'($urandom);
                bcond[i] = $urandom_range(0, 1) == 1;
                waits[i] = $urandom_range(0, 3);
            end
            rom[$urandom_range(0, ROM_N - 1)] = HALT;
            run(0, 60, $urandom_range(0, 1) == 1, h);
            if (h) run(1, 30, 0, h);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
